// File: rtl/pingpong_bank_ctrl_pkg.sv
// Shared definitions for the ping-pong bank controller.
//   bank_state_e        : FSM state, encoded as the number of committed banks held
//   OCC_W               : width of the occupancy output (0..2 banks)
//   DEFAULT_STALL_LIMIT : default blocked-cycle count for the stall flags
//   DEFAULT_CNT_W       : default width of the stall counters
//   state_occupancy()   : maps an FSM state to its occupancy value
package pingpong_bank_ctrl_pkg;

  localparam int OCC_W               = 2;
  localparam int DEFAULT_STALL_LIMIT = 1024;
  localparam int DEFAULT_CNT_W       = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } bank_state_e;

  typedef logic [OCC_W-1:0] occ_t;

  function automatic occ_t state_occupancy(input bank_state_e s);
    occ_t occ;
    case (s)
      ST_EMPTY: occ = 2'd0;
      ST_HALF:  occ = 2'd1;
      ST_FULL:  occ = 2'd2;
      default:  occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pingpong_bank_ctrl_if.sv
// Producer/consumer bus of the ping-pong bank controller.
//   Producer side : i_req, i_write (to controller); i_full_n, i_bank (from controller)
//   Consumer side : t_req, t_read  (to controller); t_empty_n, t_bank (from controller)
//   Status        : occupancy, stall_prod, stall_cons, err_ovf, err_udf (from controller)
//   Control       : err_clr (to controller)
// Modports: master = the producer/consumer environment, slave = the controller.
interface pingpong_bank_ctrl_if;
  import pingpong_bank_ctrl_pkg::*;

  logic i_req;
  logic i_write;
  logic i_full_n;
  logic i_bank;
  logic t_req;
  logic t_read;
  logic t_empty_n;
  logic t_bank;
  occ_t occupancy;
  logic stall_prod;
  logic stall_cons;
  logic err_ovf;
  logic err_udf;
  logic err_clr;

  modport master (
    output i_req, i_write, t_req, t_read, err_clr,
    input  i_full_n, i_bank, t_empty_n, t_bank, occupancy,
           stall_prod, stall_cons, err_ovf, err_udf
  );

  modport slave (
    input  i_req, i_write, t_req, t_read, err_clr,
    output i_full_n, i_bank, t_empty_n, t_bank, occupancy,
           stall_prod, stall_cons, err_ovf, err_udf
  );

endinterface

// File: rtl/stall_watchdog.sv
// Counts consecutive cycles in which a requester is blocked and raises a
// registered stall flag once the count reaches STALL_LIMIT.
//   clock   : rising-edge clock
//   reset   : asynchronous, active-low reset
//   blocked : requester is asking but cannot proceed this cycle
//   stall   : high while the blocked-cycle count equals STALL_LIMIT
// The counter clears on any unblocked cycle and saturates at STALL_LIMIT.
// STALL_LIMIT must be representable in CNT_W bits.
module stall_watchdog #(
  parameter int CNT_W       = 16,
  parameter int STALL_LIMIT = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic blocked,
  output logic stall
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STALL_LIMIT);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    cnt_next = '0;
    if (blocked) begin
      cnt_next = (cnt == LIMIT) ? cnt : cnt + CNT_W'(1);
    end
  end

  // The flag is loaded from the next count so it rises on the same edge the
  // counter reaches the limit, while still coming straight from a flop.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      stall <= 1'b0;
    end else begin
      cnt   <= cnt_next;
      stall <= (cnt_next == LIMIT);
    end
  end

endmodule

// File: rtl/pingpong_bank_ctrl.sv
// Ping-pong (double-buffer) bank controller.
// A producer fills one of two banks and commits it with i_write; a consumer
// reads committed banks in order and releases each with t_read. The FSM state
// counts committed banks (EMPTY/HALF/FULL); two one-bit pointers select the
// bank each side works on.
//   clock : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : pingpong_bank_ctrl_if.slave -- handshakes, bank indices,
//           occupancy, stall flags, sticky error flags and err_clr
// Every output comes from a flop or a decode of the state register, so no
// input reaches an output combinationally.
module pingpong_bank_ctrl
  import pingpong_bank_ctrl_pkg::*;
#(
  parameter int STALL_LIMIT = DEFAULT_STALL_LIMIT,
  parameter int CNT_W       = DEFAULT_CNT_W
) (
  input  logic                 clock,
  input  logic                 reset,
  pingpong_bank_ctrl_if.slave  bus
);

  bank_state_e state;
  bank_state_e state_next;

  logic wr_ptr;
  logic rd_ptr;
  logic full_n;
  logic empty_n;
  occ_t occ;
  logic wr_acc;
  logic rd_acc;
  logic err_ovf_q;
  logic err_udf_q;
  logic prod_blocked;
  logic cons_blocked;
  logic stall_prod_w;
  logic stall_cons_w;

  // Requests are qualified by the registered availability flags, so an
  // attempt against a full/empty controller is simply not accepted.
  assign wr_acc = bus.i_write & full_n;
  assign rd_acc = bus.t_read  & empty_n;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the always blocks are evaluated.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      ST_EMPTY: begin
        if (wr_acc) state_next = ST_HALF;
      end
      ST_HALF: begin
        // A simultaneous commit and release leaves one bank held.
        if (wr_acc && !rd_acc) begin
          state_next = ST_FULL;
        end else if (!wr_acc && rd_acc) begin
          state_next = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (rd_acc) state_next = ST_HALF;
      end
      default: state_next = ST_EMPTY;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output decode (state register only)
  // ---------------------------------------------------------------------------
  always_comb begin
    occ     = state_occupancy(state);
    full_n  = (state != ST_FULL);
    empty_n = (state != ST_EMPTY);
  end

  // ---------------------------------------------------------------------------
  // Bank pointers: each accepted event flips its side to the other bank.
  // With two banks the pointers agree whenever the controller is EMPTY or FULL.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= ~wr_ptr;
      if (rd_acc) rd_ptr <= ~rd_ptr;
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky protocol errors; err_clr wins over a same-cycle new error.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else if (bus.err_clr) begin
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else begin
      if (bus.i_write && !full_n)  err_ovf_q <= 1'b1;
      if (bus.t_read  && !empty_n) err_udf_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Stall watchdogs
  // ---------------------------------------------------------------------------
  assign prod_blocked = bus.i_req & ~full_n;
  assign cons_blocked = bus.t_req & ~empty_n;

  stall_watchdog #(
    .CNT_W       (CNT_W),
    .STALL_LIMIT (STALL_LIMIT)
  ) u_prod_wdog (
    .clock   (clock),
    .reset   (reset),
    .blocked (prod_blocked),
    .stall   (stall_prod_w)
  );

  stall_watchdog #(
    .CNT_W       (CNT_W),
    .STALL_LIMIT (STALL_LIMIT)
  ) u_cons_wdog (
    .clock   (clock),
    .reset   (reset),
    .blocked (cons_blocked),
    .stall   (stall_cons_w)
  );

  // ---------------------------------------------------------------------------
  // Bus outputs
  // ---------------------------------------------------------------------------
  assign bus.i_full_n   = full_n;
  assign bus.t_empty_n  = empty_n;
  assign bus.occupancy  = occ;
  assign bus.i_bank     = wr_ptr;
  assign bus.t_bank     = rd_ptr;
  assign bus.err_ovf    = err_ovf_q;
  assign bus.err_udf    = err_udf_q;
  assign bus.stall_prod = stall_prod_w;
  assign bus.stall_cons = stall_cons_w;

endmodule

// File: doc/pingpong_bank_ctrl.md
PINGPONG_BANK_CTRL -- requirements
Module: pingpong_bank_ctrl

Interface
REQ-001 Parameter: STALL_LIMIT, default 1024, blocked-cycle count at which a stall flag asserts.
REQ-002 Parameter: CNT_W, default 16, stall counter width; STALL_LIMIT SHALL fit in CNT_W bits.
REQ-003 clock  in  1  sole clock, all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 i_req  in  1  producer wants to write a bank.
REQ-006 i_write  in  1  producer commits the bank at i_bank.
REQ-007 i_full_n  out  1  a free bank exists for the producer.
REQ-008 i_bank  out  1  bank index the producer writes.
REQ-009 t_req  in  1  consumer wants a bank to read.
REQ-010 t_read  in  1  consumer releases the bank at t_bank.
REQ-011 t_empty_n  out  1  a committed bank exists for the consumer.
REQ-012 t_bank  out  1  bank index the consumer reads.
REQ-013 occupancy  out  2  committed banks held, 0..2.
REQ-014 stall_prod  out  1  producer blocked for at least STALL_LIMIT consecutive cycles.
REQ-015 stall_cons  out  1  consumer blocked for at least STALL_LIMIT consecutive cycles.
REQ-016 err_ovf  out  1  sticky: i_write seen while i_full_n=0.
REQ-017 err_udf  out  1  sticky: t_read seen while t_empty_n=0.
REQ-018 err_clr  in  1  synchronous clear of err_ovf and err_udf.

Function
REQ-019 FSM states EMPTY (occupancy 0), HALF (1), FULL (2); state register SHALL be the sole source of occupancy, i_full_n, t_empty_n.
REQ-020 Accepted write = i_write & i_full_n; accepted read = t_read & t_empty_n.
REQ-021 Transitions: EMPTY->HALF on accepted write; HALF->FULL on write only; HALF->EMPTY on read only; HALF->HALF on simultaneous accepted write and read; FULL->HALF on accepted read.
REQ-022 Accepted write toggles write pointer (i_bank); accepted read toggles read pointer (t_bank); simultaneous events toggle both in the same cycle.
REQ-023 i_full_n = (state != FULL); t_empty_n = (state != EMPTY); no combinational path from any input to any output.
REQ-024 Latency: write committed at edge N yields t_empty_n=1 from cycle N+1; read at edge N in FULL yields i_full_n=1 from cycle N+1.
REQ-025 i_write while i_full_n=0: ignored, no state/pointer change, err_ovf set next cycle.
REQ-026 t_read while t_empty_n=0: ignored, no state/pointer change, err_udf set next cycle.
REQ-027 err_clr has priority over a same-cycle error set; errors are otherwise held until reset.
REQ-028 Producer stall counter increments each cycle i_req & ~i_full_n, clears to 0 in any other cycle, saturates at STALL_LIMIT.
REQ-029 stall_prod = (producer counter == STALL_LIMIT), registered; consumer counter and stall_cons identical using t_req & ~t_empty_n.
REQ-030 Pointer wrap: toggling past bank 1 returns to bank 0; i_bank == t_bank whenever state is EMPTY or FULL.

Reset
REQ-031 On reset low, immediately: state EMPTY, both pointers 0, occupancy 0, i_full_n 1, t_empty_n 0, stall counters 0, stall flags 0, errors 0.
REQ-032 Reset mid-operation discards all committed banks; no accepted event in the reset cycle takes effect.
REQ-033 Deassertion SHALL need no synchronisation inside the block; first accepted event is at the first rising edge after release.

Structure
REQ-034 Shared package holds the FSM state enum, occupancy width (2), and default STALL_LIMIT/CNT_W constants.
REQ-035 One sub-module, stall_watchdog (CNT_W, STALL_LIMIT; in: blocked; out: stall), instantiated twice.

Verification
REQ-036 Write at cycle 1, read at cycle 3 -> t_empty_n=1 at 2, t_bank=0, occupancy 1 then 0 at 4, i_bank=1 at 2.
REQ-037 Two writes, third i_write held -> i_full_n=0 after second, err_ovf=1, occupancy stays 2, pointers unchanged.
REQ-038 HALF, simultaneous accepted write and read -> occupancy stays 1, i_bank and t_bank both toggle.
REQ-039 STALL_LIMIT=8, FULL with i_req held 8 cycles -> stall_prod=1 after 8th blocked cycle; one t_read -> counter 0, stall_prod=0 next cycle.
REQ-040 t_read in EMPTY then err_clr -> err_udf=1 next cycle, 0 after clear; err_clr with coincident new error -> err_udf=0.
REQ-041 Reset asserted in FULL with stall_cons=1 -> all outputs at REQ-031 values before next clock edge.
